anton_neopixel_registers_mc: RTL and testbench

Multi-channel successor to the single-strip NeoPixel register/buffer block. Holds one pixel byte buffer and one control register set per channel, all behind one shared 8-bit bus. Adds a hardware buffer-clear sequencer, replacing the external slow-init handshake, and exposes a registered pixel read port per channel for the stream engines instead of the whole array. Sits between the bus bridge (APB wrapper) and CHANNELS instances of the stream/timing engine.

---
 rtl/anton_neopixel_registers_mc.sv | 268 ++++++++++++++++++++++++++
 tb/tb_anton_neopixel_registers_mc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_registers_mc.sv
// anton_neopixel_registers_mc
// ---------------------------------------------------------------------------
// Multi-channel NeoPixel register/buffer block. Each channel owns a pixel
// byte buffer, a control register set and a hardware buffer-clear
// sequencer. All channels sit behind one shared 8-bit bus. Each channel also
// has a registered pixel read port for its stream engine.
//
// Bus address layout: [15:14] channel, [13] 0=buffer / 1=register,
// [12:0] offset. Registers per channel (offset[2:0]):
//   0 max[7:0]   1 max[12:8]   2 ctrl {3'b0,32bit,loop,run,limit,init}
//   3 status {5'b0,wrErr,clearBusy,state} (bit 2 write-1 clears wrErr)
//   4 irq control {6'b0,irqEn,frameDone} when ANTON_NEOPIXEL_IRQ_EN is set
//
// Configuration macros:
//   BUFFER_END_DEFAULT     default last buffer index (99 if not defined)
//   ANTON_NEOPIXEL_IRQ_EN  adds the frame-done interrupt and output irq
//
// Ports:
//   busClk, busResetN      clock, asynchronous active-low reset
//   busAddr, busDataIn     bus address and write data
//   busWrite, busRead      one-cycle access strobes
//   busDataOut             registered read data (1 cycle after busRead)
//   pixelAddr, pixelData   per-channel engine read index / registered byte
//   stream_sync_of         per-channel end-of-frame pulse
//   syncStart              per-channel start request
//   state                  per-channel engine state bit for status readback
//   reg_max, reg_ctrl_*    per-channel register outputs to the engines
//   clearBusy              per-channel clear sequencer active
//   irq                    (ANTON_NEOPIXEL_IRQ_EN only) frame-done interrupt
// ---------------------------------------------------------------------------

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 99
`endif

module anton_neopixel_registers_mc #(
  parameter int CHANNELS   = 2,
  parameter int BUFFER_END = `BUFFER_END_DEFAULT,
  parameter int CH_BITS    = 2
) (
  input  logic                                          busClk,
  input  logic                                          busResetN,
  input  logic [15:0]                                   busAddr,
  input  logic [7:0]                                    busDataIn,
  input  logic                                          busWrite,
  input  logic                                          busRead,
  output logic [7:0]                                    busDataOut,
  input  logic [CHANNELS*$clog2(BUFFER_END+1)-1:0]      pixelAddr,
  output logic [CHANNELS*8-1:0]                         pixelData,
  input  logic [CHANNELS-1:0]                           stream_sync_of,
  input  logic [CHANNELS-1:0]                           syncStart,
  input  logic [CHANNELS-1:0]                           state,
  output logic [CHANNELS*13-1:0]                        reg_max,
  output logic [CHANNELS-1:0]                           reg_ctrl_limit,
  output logic [CHANNELS-1:0]                           reg_ctrl_run,
  output logic [CHANNELS-1:0]                           reg_ctrl_loop,
  output logic [CHANNELS-1:0]                           reg_ctrl_32bit,
  output logic [CHANNELS-1:0]                           clearBusy
`ifdef ANTON_NEOPIXEL_IRQ_EN
  ,
  output logic                                          irq
`endif
);

  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
  localparam logic [12:0] BUF_END_OFS = 13'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0] BUF_END_IDX = BUFFER_BITS'(BUFFER_END);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [CH_BITS-1:0] sel_ch;
  logic               sel_reg;
  logic [12:0]        offset;
  logic               ofs_in_range;

  assign sel_ch       = busAddr[15:16-CH_BITS];
  assign sel_reg      = busAddr[13];
  assign offset       = busAddr[12:0];
  assign ofs_in_range = (offset <= BUF_END_OFS);

  // Per-channel read data, muxed onto the shared bus below.
  logic [CHANNELS-1:0][7:0] ch_rd;

`ifdef ANTON_NEOPIXEL_IRQ_EN
  logic [CHANNELS-1:0] irq_req;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [7:0]             mem [BUFFER_END+1];
    logic [1:0]             clr_state;
    logic [BUFFER_BITS-1:0] clr_cnt;
    logic [12:0]            max_q;
    logic                   limit_q, run_q, loop_q, b32_q, wr_err_q;
    logic [7:0]             pix_q;
    logic [7:0]             rd_data;
    logic [BUFFER_BITS-1:0] pix_idx;
    logic                   hit, busy, buf_wr, reg_wr, ctrl_wr, ctrl_accept;

    assign hit     = (sel_ch == CH_BITS'(g));
    assign busy    = (clr_state != ST_IDLE);
    assign buf_wr  = busWrite && hit && !sel_reg;
    assign reg_wr  = busWrite && hit && sel_reg;
    assign ctrl_wr = reg_wr && (offset[2:0] == 3'd2);
    // A ctrl write with init=0 outside the clear sequence loads the ctrl
    // bits; a write with init=1 only starts the sequencer.
    assign ctrl_accept = ctrl_wr && !busy && !busDataIn[0];
    assign pix_idx = pixelAddr[g*BUFFER_BITS +: BUFFER_BITS];

    // Clear sequencer: walk the buffer zeroing one byte per cycle, then a
    // single DONE cycle restores the control registers. A second init write
    // while clearing does not restart the walk.
    always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
        clr_state <= ST_IDLE;
        clr_cnt   <= '0;
      end else begin
        case (clr_state)
          ST_IDLE: begin
            if (ctrl_wr && busDataIn[0]) begin
              clr_state <= ST_CLEAR;
              clr_cnt   <= '0;
            end
          end
          ST_CLEAR: begin
            if (clr_cnt == BUF_END_IDX) clr_state <= ST_DONE;
            else                        clr_cnt   <= clr_cnt + 1'b1;
          end
          ST_DONE: clr_state <= ST_IDLE;
          default: clr_state <= ST_IDLE;
        endcase
      end
    end

    // Buffer storage has a single write port shared by the sequencer and the
    // bus; bus writes are locked out for the whole busy window.
    always_ff @(posedge busClk) begin
      if (clr_state == ST_CLEAR)
        mem[clr_cnt] <= '0;
      else if (buf_wr && !busy && ofs_in_range)
        mem[offset[BUFFER_BITS-1:0]] <= busDataIn;
    end

    // Engine pixel port, one cycle latency, out-of-range indices read 0.
    always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) pix_q <= '0;
      else            pix_q <= (pix_idx <= BUF_END_IDX) ? mem[pix_idx] : 8'h00;
    end

    // Control registers. run has its own priority chain: clear DONE, then
    // engine start, then end-of-frame (keep running only when looping), then
    // the bus.
    always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
        max_q    <= BUF_END_OFS;
        limit_q  <= 1'b0;
        run_q    <= 1'b0;
        loop_q   <= 1'b0;
        b32_q    <= 1'b0;
        wr_err_q <= 1'b0;
      end else begin
        if (clr_state == ST_DONE)
          max_q <= BUF_END_OFS;
        else if (reg_wr && offset[2:0] == 3'd0)
          max_q[7:0] <= busDataIn;
        else if (reg_wr && offset[2:0] == 3'd1)
          max_q[12:8] <= busDataIn[4:0];

        if (clr_state == ST_DONE) begin
          limit_q <= 1'b0;
          loop_q  <= 1'b0;
          b32_q   <= 1'b0;
        end else if (ctrl_accept) begin
          limit_q <= busDataIn[1];
          loop_q  <= busDataIn[3];
          b32_q   <= busDataIn[4];
        end

        if (clr_state == ST_DONE)  run_q <= 1'b0;
        else if (syncStart[g])     run_q <= 1'b1;
        else if (stream_sync_of[g]) run_q <= loop_q;
        else if (ctrl_accept)      run_q <= busDataIn[2];

        if (buf_wr && busy)
          wr_err_q <= 1'b1;
        else if (reg_wr && offset[2:0] == 3'd3 && busDataIn[2])
          wr_err_q <= 1'b0;
      end
    end

`ifdef ANTON_NEOPIXEL_IRQ_EN
    logic irq_en_q, frame_done_q, loop_now;

    // A frame ending in the same cycle loop is written 0 counts as final.
    assign loop_now = ctrl_accept ? busDataIn[3] : loop_q;

    // frameDone: set on a non-looping end of frame, write-1-to-clear; a new
    // event wins over a simultaneous clear.
    always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
        irq_en_q     <= 1'b0;
        frame_done_q <= 1'b0;
      end else begin
        if (reg_wr && offset[2:0] == 3'd4) irq_en_q <= busDataIn[1];
        if (stream_sync_of[g] && !loop_now)
          frame_done_q <= 1'b1;
        else if (reg_wr && offset[2:0] == 3'd4 && busDataIn[0])
          frame_done_q <= 1'b0;
      end
    end

    assign irq_req[g] = irq_en_q & frame_done_q;
`endif

    // Bus read data for this channel.
    always_comb begin
      rd_data = 8'h00;
      if (sel_reg) begin
        case (offset[2:0])
          3'd0: rd_data = max_q[7:0];
          3'd1: rd_data = {3'b000, max_q[12:8]};
          3'd2: rd_data = {3'b000, b32_q, loop_q, run_q, limit_q, busy};
          3'd3: rd_data = {5'b00000, wr_err_q, busy, state[g]};
`ifdef ANTON_NEOPIXEL_IRQ_EN
          3'd4: rd_data = {6'b000000, irq_en_q, frame_done_q};
`endif
          default: rd_data = 8'h00;
        endcase
      end else if (ofs_in_range) begin
        rd_data = mem[offset[BUFFER_BITS-1:0]];
      end
    end

    assign ch_rd[g]              = rd_data;
    assign pixelData[g*8 +: 8]   = pix_q;
    assign reg_max[g*13 +: 13]   = max_q;
    assign reg_ctrl_limit[g]     = limit_q;
    assign reg_ctrl_run[g]       = run_q;
    assign reg_ctrl_loop[g]      = loop_q;
    assign reg_ctrl_32bit[g]     = b32_q;
    assign clearBusy[g]          = busy;
  end

  // Channel select for reads; unpopulated channel indices read 0.
  logic [7:0] rd_mux;
  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < CHANNELS; i++)
      if (sel_ch == CH_BITS'(i)) rd_mux = ch_rd[i];
  end

  // Read data is captured on the read strobe and held otherwise, so a
  // same-cycle write to the read address returns the old contents.
  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN)   busDataOut <= 8'h00;
    else if (busRead) busDataOut <= rd_mux;
  end

`ifdef ANTON_NEOPIXEL_IRQ_EN
  // Registered interrupt output.
  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) irq <= 1'b0;
    else            irq <= |irq_req;
  end
`endif

endmodule

// File: tb/tb_anton_neopixel_registers_mc.sv
// tb_anton_neopixel_registers_mc
// Directed bench for anton_neopixel_registers_mc with the default build
// (CHANNELS=2, BUFFER_END=99, so the buffer index is 7 bits). All inputs are
// driven and all outputs sampled on the falling clock edge.

module tb_anton_neopixel_registers_mc;

  localparam int CHANNELS   = 2;
  localparam int BUFFER_END = 99;
  localparam int BITS       = 7;

  logic                     busClk = 1'b0;
  logic                     busResetN;
  logic [15:0]              busAddr;
  logic [7:0]               busDataIn;
  logic                     busWrite;
  logic                     busRead;
  logic [7:0]               busDataOut;
  logic [CHANNELS*BITS-1:0] pixelAddr;
  logic [CHANNELS*8-1:0]    pixelData;
  logic [CHANNELS-1:0]      streamSyncOf;
  logic [CHANNELS-1:0]      syncStart;
  logic [CHANNELS-1:0]      engState;
  logic [CHANNELS*13-1:0]   regMax;
  logic [CHANNELS-1:0]      ctrlLimit, ctrlRun, ctrlLoop, ctrl32;
  logic [CHANNELS-1:0]      clearBusy;
`ifdef ANTON_NEOPIXEL_IRQ_EN
  logic                     irq;
`endif

  int checkCount = 0;
  int errorCount = 0;

  anton_neopixel_registers_mc #(.CHANNELS(CHANNELS), .BUFFER_END(BUFFER_END)) dut (
    .busClk         (busClk),
    .busResetN      (busResetN),
    .busAddr        (busAddr),
    .busDataIn      (busDataIn),
    .busWrite       (busWrite),
    .busRead        (busRead),
    .busDataOut     (busDataOut),
    .pixelAddr      (pixelAddr),
    .pixelData      (pixelData),
    .stream_sync_of (streamSyncOf),
    .syncStart      (syncStart),
    .state          (engState),
    .reg_max        (regMax),
    .reg_ctrl_limit (ctrlLimit),
    .reg_ctrl_run   (ctrlRun),
    .reg_ctrl_loop  (ctrlLoop),
    .reg_ctrl_32bit (ctrl32),
    .clearBusy      (clearBusy)
`ifdef ANTON_NEOPIXEL_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  // 100 MHz bus clock.
  always #5 busClk = ~busClk;

  // Hard stop if the sequence ever wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] mkAddr(input int ch, input bit isReg, input int off);
    return {ch[1:0], isReg, off[12:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle, entered and left on a falling edge.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [15:0] addr,
                               input logic [7:0] data);
    busWrite  = wr;
    busRead   = rd;
    busAddr   = addr;
    busDataIn = data;
    @(negedge busClk);
    busWrite  = 1'b0;
    busRead   = 1'b0;
  endtask

  task automatic busWr(input logic [15:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
  endtask

  task automatic readCheck(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    applyStimulus(1'b0, 1'b1, addr, 8'h00);
    checkOutput(tag, busDataOut, exp);
  endtask

  task automatic pulse(input logic [CHANNELS-1:0] ss, input logic [CHANNELS-1:0] sof);
    syncStart    = ss;
    streamSyncOf = sof;
    @(negedge busClk);
    syncStart    = '0;
    streamSyncOf = '0;
  endtask

  int busyCycles;
  logic [7:0] orAcc;

  initial begin
    busResetN = 1'b1;
    busAddr = '0; busDataIn = '0; busWrite = 0; busRead = 0;
    pixelAddr = '0; streamSyncOf = '0; syncStart = '0; engState = '0;
    #3 busResetN = 1'b0;
    @(negedge busClk);

    // Reset values.
    checkOutput("rst_dataout", busDataOut, 8'h00);
    checkOutput("rst_max", regMax, {13'd99, 13'd99});
    checkOutput("rst_ctrl", {ctrlLimit, ctrlRun, ctrlLoop, ctrl32}, 8'h00);
    checkOutput("rst_busy", clearBusy, 2'b00);
    checkOutput("rst_pixel", pixelData, 16'h0000);
    @(negedge busClk);
    busResetN = 1'b1;
    @(negedge busClk);

    // Read latency: nothing before the edge, value after it, then held.
    busRead = 1'b1; busAddr = mkAddr(0, 1, 0);
    #1 checkOutput("rd_not_early", busDataOut, 8'h00);
    @(negedge busClk);
    busRead = 1'b0;
    checkOutput("rd_reg0", busDataOut, 8'h63);
    busAddr = mkAddr(0, 1, 2);
    @(negedge busClk);
    checkOutput("rd_held", busDataOut, 8'h63);
    readCheck("rd_reg1", mkAddr(0, 1, 1), 8'h00);
    readCheck("rd_ctrl", mkAddr(0, 1, 2), 8'h00);

    // max register: upper bits of reg1 are not stored.
    busWr(mkAddr(0, 1, 0), 8'h34);
    busWr(mkAddr(0, 1, 1), 8'hFF);
    readCheck("rd_max_hi", mkAddr(0, 1, 1), 8'h1F);
    checkOutput("max_out", regMax[12:0], 13'h1F34);

    // Buffer writes and pixel ports, including last index and dropped ones.
    busWr(mkAddr(0, 0, 5), 8'h11);
    busWr(mkAddr(1, 0, 5), 8'hA5);
    busWr(mkAddr(1, 0, 99), 8'h3C);
    busWr(mkAddr(1, 0, 100), 8'h77);
    busWr(mkAddr(1, 0, 13'h1005), 8'h66);
    pixelAddr = {7'd5, 7'd5};
    @(negedge busClk);
    checkOutput("pix_ch1", pixelData[15:8], 8'hA5);
    checkOutput("pix_ch0", pixelData[7:0], 8'h11);
    pixelAddr = {7'd100, 7'd5};
    @(negedge busClk);
    checkOutput("pix_oob", pixelData[15:8], 8'h00);
    readCheck("buf_last", mkAddr(1, 0, 99), 8'h3C);
    readCheck("buf_oob", mkAddr(1, 0, 100), 8'h00);

    // Simultaneous read and write of the same byte returns the old value.
    applyStimulus(1'b1, 1'b1, mkAddr(1, 0, 5), 8'h5A);
    checkOutput("rw_old", busDataOut, 8'hA5);
    readCheck("rw_new", mkAddr(1, 0, 5), 8'h5A);

    // Clear channel 0, with accesses interleaved during the busy window.
    busWr(mkAddr(0, 1, 2), 8'h01);
    busyCycles = 0;
    while (clearBusy[0] && busyCycles < 1000) begin
      busWrite = 1'b0; busRead = 1'b0;
      case (busyCycles)
        5:  begin busWrite = 1'b1; busAddr = mkAddr(0, 0, 3); busDataIn = 8'hEE; end
        6:  begin busRead = 1'b1; busAddr = mkAddr(0, 1, 3); end
        7:  checkOutput("status_busy", busDataOut, 8'h06);
        8:  begin busRead = 1'b1; busAddr = mkAddr(0, 1, 2); end
        9:  checkOutput("ctrl_init_busy", busDataOut, 8'h01);
        10: begin busWrite = 1'b1; busAddr = mkAddr(0, 1, 2); busDataIn = 8'h0D; end
        12: begin
              checkOutput("ctrl_ignored", ctrlRun[0], 1'b0);
              checkOutput("ch1_not_busy", clearBusy[1], 1'b0);
            end
        default: ;
      endcase
      busyCycles++;
      @(negedge busClk);
    end
    busWrite = 1'b0; busRead = 1'b0;
    checkOutput("clear_len", busyCycles, BUFFER_END + 2);
    readCheck("ctrl_after_clr", mkAddr(0, 1, 2), 8'h00);
    checkOutput("max_after_clr", regMax[12:0], 13'd99);
    readCheck("wrerr_sticky", mkAddr(0, 1, 3), 8'h04);
    busWr(mkAddr(0, 1, 3), 8'h04);
    readCheck("wrerr_clr", mkAddr(0, 1, 3), 8'h00);
    orAcc = 8'h00;
    for (int i = 0; i <= BUFFER_END; i++) begin
      pixelAddr[6:0] = 7'(i);
      @(negedge busClk);
      orAcc = orAcc | pixelData[7:0];
    end
    checkOutput("buf_zeroed", orAcc, 8'h00);
    readCheck("ch1_kept", mkAddr(1, 0, 5), 8'h5A);

    // run priority.
    busWr(mkAddr(0, 1, 2), 8'h0C);
    checkOutput("run_loop_set", {ctrlRun[0], ctrlLoop[0]}, 2'b11);
    pulse(2'b00, 2'b01);
    checkOutput("run_loop_keep", ctrlRun[0], 1'b1);
    busWr(mkAddr(0, 1, 2), 8'h04);
    pulse(2'b00, 2'b01);
    checkOutput("run_stop", ctrlRun[0], 1'b0);
    pulse(2'b01, 2'b01);
    checkOutput("start_wins", ctrlRun[0], 1'b1);
    busWr(mkAddr(0, 1, 2), 8'h12);
    checkOutput("ctrl_bits", {ctrl32[0], ctrlLoop[0], ctrlRun[0], ctrlLimit[0]}, 4'b1001);
    readCheck("ctrl_rd", mkAddr(0, 1, 2), 8'h12);
    syncStart = 2'b01;
    busWr(mkAddr(0, 1, 2), 8'h00);
    syncStart = 2'b00;
    checkOutput("start_over_bus", ctrlRun[0], 1'b1);

    // Unpopulated channel and unused registers.
    busWr(mkAddr(3, 1, 0), 8'h55);
    busWr(mkAddr(3, 0, 5), 8'h99);
    busWr(mkAddr(0, 1, 5), 8'hFF);
    readCheck("pre_nonzero", mkAddr(1, 0, 5), 8'h5A);
    readCheck("ch3_reg", mkAddr(3, 1, 0), 8'h00);
    readCheck("ch3_buf", mkAddr(3, 0, 5), 8'h00);
    checkOutput("ch3_no_effect", regMax, {13'd99, 13'd99});
    readCheck("reg5", mkAddr(0, 1, 5), 8'h00);
`ifndef ANTON_NEOPIXEL_IRQ_EN
    busWr(mkAddr(0, 1, 4), 8'h03);
    readCheck("reg4_absent", mkAddr(0, 1, 4), 8'h00);
`else
    busWr(mkAddr(1, 1, 4), 8'h02);
    pulse(2'b00, 2'b10);
    @(negedge busClk);
    checkOutput("irq_set", irq, 1'b1);
    readCheck("reg4_rd", mkAddr(1, 1, 4), 8'h03);
    busWr(mkAddr(1, 1, 4), 8'h01);
    @(negedge busClk);
    checkOutput("irq_clr", irq, 1'b0);
`endif

    // Engine state bit in status.
    engState = 2'b10;
    readCheck("status_state", mkAddr(1, 1, 3), 8'h01);

    // Reset in the middle of a clear aborts it.
    busWr(mkAddr(1, 1, 2), 8'h01);
    repeat (10) @(negedge busClk);
    checkOutput("clr_running", clearBusy[1], 1'b1);
    busResetN = 1'b0;
    #1 checkOutput("clr_abort", clearBusy, 2'b00);
    @(negedge busClk);
    busResetN = 1'b1;
    @(negedge busClk);
    readCheck("ctrl_post_rst", mkAddr(1, 1, 2), 8'h00);
    checkOutput("run_post_rst", ctrlRun, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
